// File: rtl/prbs_checker_if.sv
// Bundle of the serial input, clear and status signals of the PRBS checker.
// The master side drives bits and clear; the slave side is the checker itself.
interface prbs_checker_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             err_clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, in_bit, err_clr,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  in_valid, in_bit, err_clr,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the serial stream of a Fibonacci LFSR generator.
// Hunts for a seed, verifies it over LOCK_CNT bits, then free-runs and counts bit errors.
module prbs_checker #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1001,
    parameter int               LOCK_CNT   = 8,
    parameter int               WIN        = 32,
    parameter int               UNLOCK_ERR = 4,
    parameter int               ERR_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    prbs_checker_if.slave  bus
);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    state_t             state,     state_n;
    logic [WIDTH-1:0]   hist,      hist_n;
    logic [FILL_W-1:0]  fill_cnt,  fill_cnt_n;
    logic [MATCH_W-1:0] match_cnt, match_cnt_n;
    logic [WIN_W-1:0]   win_cnt,   win_cnt_n;
    logic [WERR_W-1:0]  win_err,   win_err_n;
    logic               err_pulse, err_pulse_n;
    logic [ERR_W-1:0]   err_count, err_count_n;
    logic               expected;
    logic               mismatch;

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_cnt_n  = fill_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_pulse_n = 1'b0;
        err_count_n = err_count;
        expected    = ^(hist & TAPS);
        mismatch    = (bus.in_bit != expected);

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    hist_n = {hist[WIDTH-2:0], bus.in_bit};
                    if (fill_cnt == FILL_W'(WIDTH - 1)) begin
                        state_n     = SYNC;
                        fill_cnt_n  = '0;
                        match_cnt_n = '0;
                    end else begin
                        fill_cnt_n = fill_cnt + FILL_W'(1);
                    end
                end
                SYNC: begin
                    hist_n = {hist[WIDTH-2:0], bus.in_bit};
                    // An all-zero history predicts zeros forever, so it never earns a match.
                    if (hist == '0 || mismatch) begin
                        match_cnt_n = '0;
                    end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        state_n     = LOCKED;
                        match_cnt_n = '0;
                        win_cnt_n   = '0;
                        win_err_n   = '0;
                    end else begin
                        match_cnt_n = match_cnt + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a bad bit cannot corrupt later predictions.
                    hist_n = {hist[WIDTH-2:0], expected};
                    if (mismatch) begin
                        err_pulse_n = 1'b1;
                        if (err_count != '1) begin
                            err_count_n = err_count + ERR_W'(1);
                        end
                    end
                    if (mismatch && win_err == WERR_W'(UNLOCK_ERR - 1)) begin
                        state_n    = HUNT;
                        hist_n     = '0;
                        fill_cnt_n = '0;
                        win_cnt_n  = '0;
                        win_err_n  = '0;
                    end else if (win_cnt == WIN_W'(WIN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WIN_W'(1);
                        win_err_n = win_err + WERR_W'(mismatch);
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        if (bus.err_clr) begin
            err_count_n = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_pulse <= err_pulse_n;
            err_count <= err_count_n;
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: a 16-bit and a 3-bit-counter instance share one stream
// and are compared every cycle against a queue-based model of the checker's rules.
module tb_prbs_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic err_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prbs_checker_if #(.ERR_W(16)) bus  ();
    prbs_checker_if #(.ERR_W(3))  bus3 ();

    assign bus.in_valid  = in_valid;
    assign bus.in_bit    = in_bit;
    assign bus.err_clr   = err_clr;
    assign bus3.in_valid = in_valid;
    assign bus3.in_bit   = in_bit;
    assign bus3.err_clr  = err_clr;

    prbs_checker #(.ERR_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    prbs_checker #(.ERR_W(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    // Reference stream: one period of the default generator sequence.
    bit seq [15] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1};
    int pos = 0;

    // Behavioural model: history kept as a queue, oldest bit at the front.
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;
    int m_mode;
    bit m_hist[$];
    int m_match, m_wbits, m_werrs, m_cnt, m_cnt3;
    bit m_pulse;

    function automatic void model_reset();
        m_mode = M_HUNT;
        m_hist.delete();
        m_match = 0;
        m_wbits = 0;
        m_werrs = 0;
        m_cnt = 0;
        m_cnt3 = 0;
        m_pulse = 0;
    endfunction

    function automatic void push_hist(input bit b);
        m_hist.push_back(b);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit clr);
        bit e;
        bit allz;
        m_pulse = 0;
        if (v) begin
            if (m_mode == M_HUNT) begin
                push_hist(b);
                if (m_hist.size() == 4) begin
                    m_mode = M_SYNC;
                    m_match = 0;
                end
            end else begin
                // s[n+4] = s[n+3] ^ s[n]
                e = m_hist[3] ^ m_hist[0];
                allz = 1;
                foreach (m_hist[i]) if (m_hist[i]) allz = 0;
                if (m_mode == M_SYNC) begin
                    push_hist(b);
                    if (allz || b != e) m_match = 0;
                    else begin
                        m_match++;
                        if (m_match == 8) begin
                            m_mode = M_LOCKED;
                            m_wbits = 0;
                            m_werrs = 0;
                        end
                    end
                end else begin
                    push_hist(e);
                    m_wbits++;
                    if (b != e) begin
                        m_pulse = 1;
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt3 < 7) m_cnt3++;
                        m_werrs++;
                    end
                    if (m_werrs == 4) begin
                        m_mode = M_HUNT;
                        m_hist.delete();
                    end else if (m_wbits == 32) begin
                        m_wbits = 0;
                        m_werrs = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_cnt = 0;
            m_cnt3 = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit c);
        in_valid = v;
        in_bit = b;
        err_clr = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        check("locked",     32'(bus.locked),     32'(m_mode == M_LOCKED));
        check("err_pulse",  32'(bus.err_pulse),  32'(m_pulse));
        check("err_count",  32'(bus.err_count),  32'(m_cnt));
        check("err_count3", 32'(bus3.err_count), 32'(m_cnt3));
        check("locked3",    32'(bus3.locked),    32'(m_mode == M_LOCKED));
    endtask

    // Sends the next stream bit (optionally inverted); invalid cycles carry random bits.
    task automatic send(input bit v, input bit flip, input bit c);
        bit b;
        if (v) begin
            b = seq[pos % 15] ^ flip;
            pos++;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        cycle(v, b, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            err_clr  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_locked",    32'(bus.locked),    0);
            check("rst_err_pulse", 32'(bus.err_pulse), 0);
            check("rst_err_count", 32'(bus.err_count), 0);
        end
        model_reset();
        pos = 0;
        rst_n = 1'b1;
    endtask

    task automatic align_window();
        for (int i = 0; i < 40 && m_wbits != 0; i++) send(1, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        bit v;
        #2;
        model_reset();

        // Reset, then lock on the default stream
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(1, 0, 0);
            if (i == 10) check("pre_lock_11", 32'(bus.locked), 0);
            if (i == 11) check("lock_at_12", 32'(bus.locked), 1);
        end
        check("no_err_300", 32'(bus.err_count), 0);

        // Single error, no propagation
        send(1, 1, 0);
        check("single_pulse", 32'(bus.err_pulse), 1);
        check("single_count", 32'(bus.err_count), 1);
        check("single_locked", 32'(bus.locked), 1);
        for (int i = 0; i < 40; i++) send(1, 0, 0);
        check("single_no_prop", 32'(bus.err_count), 1);

        // Three errors in one window hold lock
        align_window();
        for (int i = 0; i < 40; i++) send(1, (i == 0 || i == 5 || i == 10), 0);
        check("hold_3err_locked", 32'(bus.locked), 1);
        check("hold_3err_count", 32'(bus.err_count), 4);

        // Four errors in one window drop lock, then re-lock after 12 bits
        align_window();
        for (int i = 0; i < 7; i++) send(1, (i % 2 == 0), 0);
        check("unlock_locked", 32'(bus.locked), 0);
        check("unlock_count", 32'(bus.err_count), 8);
        for (int i = 0; i < 12; i++) begin
            send(1, 0, 0);
            if (i == 10) check("relock_pre", 32'(bus.locked), 0);
            if (i == 11) check("relock_12", 32'(bus.locked), 1);
        end

        // All-zero stream never locks
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1, 0, 0);
        check("zero_no_lock", 32'(bus.locked), 0);
        check("zero_no_err", 32'(bus.err_count), 0);

        // Mismatch after 7 matches restarts the match run
        do_reset();
        for (int i = 0; i < 24; i++) begin
            send(1, (i == 11), 0);
            if (i == 22) check("late_lock_pre", 32'(bus.locked), 0);
            if (i == 23) check("late_lock", 32'(bus.locked), 1);
        end

        // Random in_valid gaps give the same lock point in valid bits
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 400 && nvalid < 12; i++) begin
            v = 1'($urandom_range(0, 1));
            send(v, 0, 0);
            if (v) nvalid++;
            check("gap_lock", 32'(bus.locked), 32'(nvalid >= 12));
        end

        // Clear wins over a simultaneous error
        send(1, 1, 0);
        for (int i = 0; i < 3; i++) send(1, 0, 0);
        send(1, 1, 1);
        check("clr_count", 32'(bus.err_count), 0);
        check("clr_pulse", 32'(bus.err_pulse), 1);
        check("clr_locked", 32'(bus.locked), 1);

        // Saturation of the 3-bit counter
        align_window();
        for (int k = 0; k < 10; k++) for (int j = 0; j < 11; j++) send(1, (j == 0), 0);
        check("sat_count3", 32'(bus3.err_count), 7);
        check("sat_count16", 32'(bus.err_count), 10);
        check("sat_locked", 32'(bus.locked), 1);

        // Randomised soak with gaps, errors, clears and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            send(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
